// File: rtl/mem_port_arbiter.sv
// Arbiter and sequencer for the single data-memory port. Round-robin on ties, one memory
// command cycle per access, and a fixed-latency read return to the port that issued it.
module mem_port_arbiter #(
    parameter int V      = 256,
    parameter int A      = 14,
    parameter int RD_LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic           req1,
    input  logic           we0,
    input  logic           we1,
    input  logic [A-1:0]   addr0,
    input  logic [A-1:0]   addr1,
    input  logic [V/8-1:0] be0,
    input  logic [V/8-1:0] be1,
    input  logic [V-1:0]   wdata0,
    input  logic [V-1:0]   wdata1,
    output logic           gnt0,
    output logic           gnt1,
    output logic           rvalid0,
    output logic           rvalid1,
    output logic [V-1:0]   rdata,
    output logic           busy0,
    output logic           MemRden,
    output logic           MemWren,
    output logic [A-1:0]   MemAddress,
    output logic [V/8-1:0] MemByteena,
    output logic [V-1:0]   MemWriteData,
    input  logic [V-1:0]   MemReadData
);

    localparam int BW = V / 8;
    localparam int CW = 3;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RWAIT,
        RESP
    } state_t;

    state_t        state_q;
    logic          last_q;
    logic          id_q;
    logic          we_q;
    logic [CW-1:0] cnt_q;
    logic          gnt0_q;
    logic          gnt1_q;
    logic          rvalid0_q;
    logic          rvalid1_q;
    logic [V-1:0]  rdata_q;
    logic          rden_q;
    logic          wren_q;
    logic [A-1:0]  addr_q;
    logic [BW-1:0] be_q;
    logic [V-1:0]  wdata_q;

    logic          any_req;
    logic          win_id_d;
    logic          win_we_d;
    logic [A-1:0]  win_addr_d;
    logic [BW-1:0] win_be_d;
    logic [V-1:0]  win_wdata_d;

    // Winner: a lone request wins; on a tie the port not granted last time wins.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no latch is inferred.
        any_req  = req0 | req1;
        win_id_d = 1'b0;
        if (req0 && req1) begin
            win_id_d = ~last_q;
        end else if (req1) begin
            win_id_d = 1'b1;
        end
        win_we_d    = win_id_d ? we1    : we0;
        win_addr_d  = win_id_d ? addr1  : addr0;
        win_be_d    = win_id_d ? be1    : be0;
        win_wdata_d = win_id_d ? wdata1 : wdata0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            id_q      <= 1'b0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata_q   <= '0;
            rden_q    <= 1'b0;
            wren_q    <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
        end else begin
            // NOTE: sequential state uses nonblocking assignments only, so every register
            // samples pre-edge values regardless of statement order.
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rden_q    <= 1'b0;
            wren_q    <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;

            case (state_q)
                IDLE, RESP: begin
                    state_q <= IDLE;
                    if (any_req) begin
                        // The memory command is registered here so it is driven during CMD.
                        state_q <= CMD;
                        id_q    <= win_id_d;
                        we_q    <= win_we_d;
                        gnt0_q  <= ~win_id_d;
                        gnt1_q  <= win_id_d;
                        wren_q  <= win_we_d;
                        rden_q  <= ~win_we_d;
                        addr_q  <= win_addr_d;
                        be_q    <= win_we_d ? win_be_d : '1;
                        wdata_q <= win_we_d ? win_wdata_d : '0;
                    end
                end
                CMD: begin
                    last_q <= id_q;
                    if (we_q) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= RWAIT;
                        cnt_q   <= CW'(RD_LAT);
                    end
                end
                RWAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        rdata_q   <= MemReadData;
                        rvalid0_q <= ~id_q;
                        rvalid1_q <= id_q;
                        state_q   <= RESP;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt0         = gnt0_q;
    assign gnt1         = gnt1_q;
    assign rvalid0      = rvalid0_q;
    assign rvalid1      = rvalid1_q;
    assign rdata        = rdata_q;
    assign MemRden      = rden_q;
    assign MemWren      = wren_q;
    assign MemAddress   = addr_q;
    assign MemByteena   = be_q;
    assign MemWriteData = wdata_q;

    // Held low during reset; afterwards it tracks req0 until the write grant or read return.
    assign busy0 = ~rst & req0 & ~(gnt0_q & we0) & ~rvalid0_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance "a" uses RD_LAT=2, instance "b" RD_LAT=1,
// each with its own small fixed-latency memory model.
module tb_mem_port_arbiter;

    localparam int V  = 256;
    localparam int A  = 14;
    localparam int BE = V / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- instance a (RD_LAT = 2) ----------------
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [A-1:0]  addr0 = '0, addr1 = '0;
    logic [BE-1:0] be0 = '0, be1 = '0;
    logic [V-1:0]  wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, busy0, MemRden, MemWren;
    logic [V-1:0]  rdata, MemWriteData, MemReadData;
    logic [A-1:0]  MemAddress;
    logic [BE-1:0] MemByteena;

    mem_port_arbiter #(.V(V), .A(A), .RD_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .be0(be0), .be1(be1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .busy0(busy0),
        .MemRden(MemRden), .MemWren(MemWren), .MemAddress(MemAddress),
        .MemByteena(MemByteena), .MemWriteData(MemWriteData), .MemReadData(MemReadData)
    );

    logic [V-1:0] mem_a [64];
    logic [V-1:0] pipe_a [2];
    logic [1:0]   vld_a = '0;

    initial begin
        for (int i = 0; i < 64; i++) mem_a[i] <= {8{32'(i)}};
        mem_a[32] <= 256'h1234;
        mem_a[33] <= 256'h5678;
    end

    always @(posedge clk) begin
        if (MemWren) begin
            for (int b = 0; b < BE; b++)
                if (MemByteena[b]) mem_a[MemAddress[5:0]][8*b +: 8] <= MemWriteData[8*b +: 8];
        end
        vld_a     <= {vld_a[0], MemRden};
        pipe_a[0] <= mem_a[MemAddress[5:0]];
        pipe_a[1] <= pipe_a[0];
    end
    assign MemReadData = vld_a[1] ? pipe_a[1] : {8{32'hDEAD_BEEF}};

    logic [10:0] outs_a;
    assign outs_a = {gnt0, gnt1, rvalid0, rvalid1, busy0, MemRden, MemWren,
                     |rdata, |MemAddress, |MemByteena, |MemWriteData};

    // ---------------- instance b (RD_LAT = 1) ----------------
    logic          b_req0 = 1'b0, b_we0 = 1'b0;
    logic [A-1:0]  b_addr0 = '0;
    logic [BE-1:0] b_be0 = '0;
    logic [V-1:0]  b_wdata0 = '0;
    logic          b_req1 = 1'b0, b_we1 = 1'b0;
    logic [A-1:0]  b_addr1 = '0;
    logic [BE-1:0] b_be1 = '0;
    logic [V-1:0]  b_wdata1 = '0;
    logic          b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_busy0, b_MemRden, b_MemWren;
    logic [V-1:0]  b_rdata, b_MemWriteData, b_MemReadData;
    logic [A-1:0]  b_MemAddress;
    logic [BE-1:0] b_MemByteena;

    mem_port_arbiter #(.V(V), .A(A), .RD_LAT(1)) dut_b (
        .clk(clk), .rst(rst),
        .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
        .addr0(b_addr0), .addr1(b_addr1), .be0(b_be0), .be1(b_be1),
        .wdata0(b_wdata0), .wdata1(b_wdata1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
        .rdata(b_rdata), .busy0(b_busy0),
        .MemRden(b_MemRden), .MemWren(b_MemWren), .MemAddress(b_MemAddress),
        .MemByteena(b_MemByteena), .MemWriteData(b_MemWriteData), .MemReadData(b_MemReadData)
    );

    logic [V-1:0] mem_b [64];
    logic [V-1:0] pipe_b;
    logic         vld_b = 1'b0;

    initial begin
        for (int i = 0; i < 64; i++) mem_b[i] <= {32{8'h11}};
    end

    always @(posedge clk) begin
        if (b_MemWren) begin
            for (int b = 0; b < BE; b++)
                if (b_MemByteena[b]) mem_b[b_MemAddress[5:0]][8*b +: 8] <= b_MemWriteData[8*b +: 8];
        end
        vld_b  <= b_MemRden;
        pipe_b <= mem_b[b_MemAddress[5:0]];
    end
    assign b_MemReadData = vld_b ? pipe_b : {8{32'hDEAD_BEEF}};

    logic [10:0] outs_b;
    assign outs_b = {b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_busy0, b_MemRden, b_MemWren,
                     |b_rdata, |b_MemAddress, |b_MemByteena, |b_MemWriteData};

    // ---------------- helpers and tests ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req0 = 1'b1;
        #1;
        checks++;
        if (outs_a !== 11'b0) begin
            failures++; $display("FAIL reset_outputs_a got=%b exp=%b", outs_a, 11'b0);
        end
        checks++;
        if (outs_b !== 11'b0) begin
            failures++; $display("FAIL reset_outputs_b got=%b exp=%b", outs_b, 11'b0);
        end
        tick();
        tick();
        checks++;
        if (busy0 !== 1'b0) begin
            failures++; $display("FAIL reset_busy0 got=%b exp=0", busy0);
        end
        req0 = 1'b0;
        rst  = 1'b0;
        tick();
        checks++;
        if (outs_a !== 11'b0) begin
            failures++; $display("FAIL idle_after_reset got=%b exp=%b", outs_a, 11'b0);
        end
    endtask

    task automatic test_write_p0();
        tick();
        req0 = 1'b1; we0 = 1'b1; addr0 = 14'h0010; be0 = '1; wdata0 = {32{8'hA5}};
        #1;
        checks++;
        if (busy0 !== 1'b1) begin
            failures++; $display("FAIL wr_busy_t0 got=%b exp=1", busy0);
        end
        tick();
        checks++;
        if ({gnt0, gnt1, MemWren, MemRden, busy0} !== 5'b10100) begin
            failures++; $display("FAIL wr_cmd_flags got=%b exp=10100", {gnt0, gnt1, MemWren, MemRden, busy0});
        end
        checks++;
        if (MemAddress !== 14'h0010 || MemByteena !== {BE{1'b1}}) begin
            failures++; $display("FAIL wr_cmd_addr_be got=%h/%h exp=0010/ffffffff", MemAddress, MemByteena);
        end
        checks++;
        if (MemWriteData !== {32{8'hA5}}) begin
            failures++; $display("FAIL wr_cmd_data got=%h exp=%h", MemWriteData, {32{8'hA5}});
        end
        tick();
        req0 = 1'b0;
        checks++;
        if ({gnt0, MemWren, |MemAddress, |MemWriteData} !== 4'b0) begin
            failures++; $display("FAIL wr_after_cmd got=%b exp=0000", {gnt0, MemWren, |MemAddress, |MemWriteData});
        end
    endtask

    task automatic test_read_p0();
        tick();
        req0 = 1'b1; we0 = 1'b0; addr0 = 14'h0020; be0 = '0; wdata0 = '0;
        #1;
        checks++;
        if (busy0 !== 1'b1) begin
            failures++; $display("FAIL rd_busy_t0 got=%b exp=1", busy0);
        end
        tick();
        checks++;
        if ({gnt0, gnt1, MemRden, MemWren, busy0} !== 5'b10101) begin
            failures++; $display("FAIL rd_cmd_flags got=%b exp=10101", {gnt0, gnt1, MemRden, MemWren, busy0});
        end
        checks++;
        if (MemAddress !== 14'h0020 || MemByteena !== {BE{1'b1}} || MemWriteData !== '0) begin
            failures++; $display("FAIL rd_cmd_fields got=%h/%h/%h", MemAddress, MemByteena, MemWriteData);
        end
        for (int t = 2; t <= 3; t++) begin
            tick();
            checks++;
            if ({MemRden, rvalid0, busy0} !== 3'b001) begin
                failures++; $display("FAIL rd_wait_t%0d got=%b exp=001", t, {MemRden, rvalid0, busy0});
            end
        end
        tick();
        checks++;
        if ({rvalid0, rvalid1, busy0} !== 3'b100 || rdata !== 256'h1234) begin
            failures++; $display("FAIL rd_resp got=%b rdata=%h exp=100 rdata=1234", {rvalid0, rvalid1, busy0}, rdata);
        end
        req0 = 1'b0;
        tick();
        checks++;
        if (rvalid0 !== 1'b0 || rdata !== 256'h1234) begin
            failures++; $display("FAIL rd_hold got=%b rdata=%h exp=0 rdata=1234", rvalid0, rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_v;
        tick();
        rst  = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 14'h0020;
        req1 = 1'b1; we1 = 1'b0; addr1 = 14'h0021;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_v = {(k == 1 || k == 9), (k == 5 || k == 13), (k == 4 || k == 12), (k == 8 || k == 16)};
            checks++;
            if ({gnt0, gnt1, rvalid0, rvalid1} !== exp_v) begin
                failures++; $display("FAIL rr_cycle%0d got=%b exp=%b", k, {gnt0, gnt1, rvalid0, rvalid1}, exp_v);
            end
            if (exp_v[1]) begin
                checks++;
                if (rdata !== 256'h1234) begin
                    failures++; $display("FAIL rr_rdata0_cycle%0d got=%h exp=1234", k, rdata);
                end
            end
            if (exp_v[0]) begin
                checks++;
                if (rdata !== 256'h5678) begin
                    failures++; $display("FAIL rr_rdata1_cycle%0d got=%h exp=5678", k, rdata);
                end
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        logic [3:0] exp_v;
        tick();
        req1 = 1'b1; we1 = 1'b0; addr1 = 14'h0021;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            failures++; $display("FAIL mid_gnt1 got=%b exp=01", {gnt0, gnt1});
        end
        req1 = 1'b0;
        tick();
        req0 = 1'b1; we0 = 1'b0; addr0 = 14'h0020;
        req1 = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (outs_a !== 11'b0) begin
            failures++; $display("FAIL mid_reset_outputs got=%b exp=%b", outs_a, 11'b0);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0) begin
                failures++; $display("FAIL mid_in_reset%0d got=%b exp=0000", k, {gnt0, gnt1, rvalid0, rvalid1});
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_v = {(k == 1), 1'b0, (k == 4), 1'b0};
            checks++;
            if ({gnt0, gnt1, rvalid0, rvalid1} !== exp_v) begin
                failures++; $display("FAIL mid_after%0d got=%b exp=%b", k, {gnt0, gnt1, rvalid0, rvalid1}, exp_v);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_no_starvation();
        int n_cmd    = 0;
        int ord0     = 0;
        logic p1_again = 1'b0;
        tick();
        req1 = 1'b1; we1 = 1'b1; addr1 = 14'h0030; be1 = '1; wdata1 = {32{8'h3C}};
        tick();
        checks++;
        if (gnt1 !== 1'b1) begin
            failures++; $display("FAIL starve_first_gnt1 got=%b exp=1", gnt1);
        end
        tick();
        req0 = 1'b1; we0 = 1'b1; addr0 = 14'h0031; be0 = '1; wdata0 = {32{8'h96}};
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (gnt0 === 1'b1 || gnt1 === 1'b1) n_cmd++;
            if (gnt0 === 1'b1 && ord0 == 0) begin
                ord0 = n_cmd;
            end else if (ord0 != 0) begin
                req0 = 1'b0;
                if (gnt1 === 1'b1) p1_again = 1'b1;
            end
        end
        req1 = 1'b0;
        checks++;
        if (ord0 < 1 || ord0 > 2) begin
            failures++; $display("FAIL starve_p0_grant_order got=%0d exp=1..2", ord0);
        end
        checks++;
        if (p1_again !== 1'b1) begin
            failures++; $display("FAIL starve_p1_resumed got=%b exp=1", p1_again);
        end
        repeat (4) tick();
        checks++;
        if (mem_a[49] !== {32{8'h96}}) begin
            failures++; $display("FAIL starve_p0_write_data got=%h exp=%h", mem_a[49], {32{8'h96}});
        end
    endtask

    task automatic test_partial_write();
        logic [V-1:0] exp_d;
        exp_d = {{28{8'h11}}, {4{8'hC3}}};
        tick();
        b_req0 = 1'b1; b_we0 = 1'b1; b_addr0 = 14'h0005; b_be0 = 32'h0000_000F; b_wdata0 = {32{8'hC3}};
        tick();
        checks++;
        if ({b_gnt0, b_MemWren} !== 2'b11 || b_MemByteena !== 32'h0000_000F) begin
            failures++; $display("FAIL pw_write_cmd got=%b be=%h exp=11 be=0000000f", {b_gnt0, b_MemWren}, b_MemByteena);
        end
        tick();
        b_we0 = 1'b0;
        tick();
        checks++;
        if ({b_gnt0, b_MemRden} !== 2'b11) begin
            failures++; $display("FAIL pw_read_cmd got=%b exp=11", {b_gnt0, b_MemRden});
        end
        tick();
        b_req0 = 1'b0;
        checks++;
        if (b_rvalid0 !== 1'b0) begin
            failures++; $display("FAIL pw_rvalid_early got=%b exp=0", b_rvalid0);
        end
        tick();
        checks++;
        if (b_rvalid0 !== 1'b1 || b_rdata !== exp_d) begin
            failures++; $display("FAIL pw_readback got=%b rdata=%h exp=1 rdata=%h", b_rvalid0, b_rdata, exp_d);
        end
    endtask

    initial begin
        test_reset();
        test_write_p0();
        test_read_p0();
        test_round_robin();
        test_reset_mid_read();
        test_no_starvation();
        test_partial_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single data-memory port (rden/wren, 14-bit word address, 32-bit byte enable, 256-bit data). Port 0 is the pipeline memory stage's data aligner; port 1 is the host/block loader that fills key, plaintext and state buffers. The arbiter serialises accesses, drives the memory command for exactly one cycle per access, and tracks fixed-latency read returns back to the originating port. It also generates the stall indication the hazard unit needs while port 0 waits.

## Interface
Parameters:
- V, 256, memory data width in bits
- A, 14, memory word-address width
- RD_LAT, 2, memory read latency in cycles (readData valid RD_LAT cycles after the rden cycle); legal range 1..7

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  access request; held with stable fields until matching gnt
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  A  word address
- be0 / be1  in  V/8  byte enables (writes only)
- wdata0 / wdata1  in  V  write data
- gnt0 / gnt1  out  1  one-cycle pulse: command issued to memory this cycle
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata holds this port's read result
- rdata  out  V  shared read-return bus
- busy0  out  1  to hazard unit: req0 & ~(gnt0 & we0) & ~rvalid0
- MemRden / MemWren  out  1  memory strobes
- MemAddress  out  A  memory address
- MemByteena  out  V/8  memory byte enable
- MemWriteData  out  V  memory write data
- MemReadData  in  V  memory read data

## Operation
- FSM states: IDLE, CMD, RWAIT, RESP.
- IDLE: if any req, pick winner, register its we/addr/be/wdata and id, go CMD; else stay.
- Winner selection: single request wins; on simultaneous req0 & req1, the port not granted last wins (round-robin). Last-grant pointer resets to 1, so port 0 wins the first tie.
- CMD (1 cycle): memory outputs driven from registered command.
  - Write: MemWren=1, MemByteena=be, MemWriteData=wdata.
  - Read: MemRden=1, MemByteena=all ones, MemWriteData=0.
  - gnt[id]=1; pointer updated.
  - Next state: write -> IDLE; read -> RWAIT with counter=RD_LAT.
- RWAIT: counter decrements each cycle. In the cycle where counter==1, MemReadData is captured into rdata at the clock edge, and the FSM goes to RESP.
- RESP (1 cycle): rvalid[id]=1. Arbitrates exactly as in IDLE: any req -> CMD, else IDLE.
- Outside CMD: MemRden=MemWren=0, MemAddress=0, MemByteena=0, MemWriteData=0.
- rdata holds its last captured value until the next capture. Write data never appears on rdata.
- Requests seen in CMD/RWAIT are not sampled; they wait. Requesters may drop req the cycle after gnt.
- Dropping req before gnt is a protocol violation; behaviour is undefined but the FSM must not hang.

## Timing
- Reset (async, immediate): state IDLE, pointer=1, counter=0. All outputs 0: gnt*, rvalid*, rdata, Mem*, busy0 (busy0 follows req0 after reset release).
- Reset mid-read: in-flight read is dropped; no rvalid follows.
- Request first seen in IDLE at cycle t: CMD/gnt at t+1.
- Write: occupancy t..t+1; next arbitration at t+2 (IDLE).
- Read: MemRden at t+1, data valid at t+1+RD_LAT, rvalid at t+2+RD_LAT; next CMD possible at t+3+RD_LAT.
- Back-to-back reads from alternating ports: one CMD every RD_LAT+2 cycles.
- Write followed by a read to the same address: the read's CMD is at least 2 cycles after the write's CMD, so it returns the written data.

## Test plan
- Port 0 write: addr=0x0010, be=0xFFFF_FFFF, wdata=all 0xA5 at t=0 -> MemWren=1, MemAddress=0x0010, gnt0=1 at t=1 only; MemWren=0 at t=2.
- Port 0 read, RD_LAT=2, memory model returns 0x1234 at t=3 -> MemRden at t=1, rvalid0 at t=4 with rdata=0x1234; busy0=1 for t=0..3, 0 at t=4.
- req0 and req1 both asserted from reset, all reads -> grants alternate 0,1,0,1. Each gnt is exactly 4 cycles after the previous rvalid-issuing CMD (RD_LAT+2).
- Port 1 holds req1 continuously (writes) while port 0 requests once -> port 0 granted no later than the second CMD after req0 rises; no starvation.
- Assert rst during RWAIT of a port-1 read -> all outputs 0 immediately; no rvalid1 ever. After release, a fresh tie grants port 0 first.
- Partial write be=0x0000_000F then read same addr with RD_LAT=1 -> only bytes 0–3 changed in returned rdata; rvalid at CMD+2.
